// File: rtl/ca_pkg.sv
// ca_pkg: shared widths, preset rule table and sequencer state codes
package ca_pkg;
  localparam int RULE_W = 8;
  localparam int COLOR_W = 6;
  localparam logic [RULE_W-1:0] PRESETS [0:7] = '{8'd30, 8'd110, 8'd22, 8'd73, 8'd90, 8'd146, 8'd105, 8'd102};
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, stable-count debounce and press pulse
module btn_debounce #(
  parameter int CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(CYCLES);
  logic s1, s2, level, flip;
  logic [CW-1:0] cnt;
  assign flip = (s2 != level) && (cnt == CW'(CYCLES - 1));
  // synchronize, count disagreement with the accepted level, flip once it has held long enough
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == level || flip) ? '0 : cnt + 1'b1;
      level <= level ^ flip;
      press <= flip & ~level;
    end
endmodule

// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer: frame-aligned rule selection from buttons, auto mode and manual byte
module ca_rule_sequencer
  import ca_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int AUTO_FRAMES = 120,
  parameter int NUM_PRESETS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_next,
  input  logic               btn_load,
  input  logic               sw_auto,
  input  logic [RULE_W-1:0]  manual_rule,
  output logic [RULE_W-1:0]  rule,
  output logic [COLOR_W-1:0] rule_color,
  output logic [2:0]         preset_idx,
  output logic               manual_active,
  output logic               reseed
);
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  logic next_press, load_press, a1, auto_on, pend_next, pend_load;
  logic do_load, do_next, do_auto, user, expire;
  logic [1:0] state;
  logic [2:0] nidx;
  logic [FW-1:0] frame_cnt;
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .rst_n(rst_n), .raw(btn_next), .press(next_press));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_load (.clk(clk), .rst_n(rst_n), .raw(btn_load), .press(load_press));
  // a press landing on the tick itself is folded into that tick's commit
  always_comb begin
    state = frame_tick ? COMMIT : (pend_next | pend_load | next_press | load_press) ? ARMED : IDLE;
    expire = auto_on && (frame_cnt == FW'(AUTO_FRAMES - 1));
    do_load = (state == COMMIT) && (pend_load | load_press);
    do_next = (state == COMMIT) && !do_load && (pend_next | next_press);
    do_auto = (state == COMMIT) && !do_load && !do_next && expire;
    user = do_load | do_next;
    nidx = (preset_idx + 3'd1) & 3'(NUM_PRESETS - 1);
  end
  // auto switch sync, pending flags (every tick commits them) and auto frame counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a1 <= 1'b0;
      auto_on <= 1'b0;
      pend_next <= 1'b0;
      pend_load <= 1'b0;
      frame_cnt <= '0;
    end else begin
      a1 <= sw_auto;
      auto_on <= a1;
      pend_next <= frame_tick ? 1'b0 : pend_next | next_press;
      pend_load <= frame_tick ? 1'b0 : pend_load | load_press;
      frame_cnt <= !auto_on ? '0 : !frame_tick ? frame_cnt : (user || expire) ? '0 : frame_cnt + 1'b1;
    end
  // committed outputs change only on the frame tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rule <= PRESETS[0];
      rule_color <= 6'd15;
      preset_idx <= 3'd0;
      manual_active <= 1'b0;
      reseed <= 1'b0;
    end else begin
      reseed <= user;
      if (do_load) begin
        rule <= manual_rule;
        rule_color <= manual_rule[6:1];
        manual_active <= 1'b1;
      end else if (do_next || do_auto) begin
        preset_idx <= nidx;
        rule <= PRESETS[nidx];
        rule_color <= PRESETS[nidx][6:1];
        manual_active <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ca_rule_sequencer.sv
// tb_ca_rule_sequencer: directed checks of commit timing, debounce, priority, auto mode and reset
module tb_ca_rule_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, btn_next = 1'b0, btn_load = 1'b0, sw_auto = 1'b0;
  logic [7:0] manual_rule = 8'd0, rule;
  logic [5:0] rule_color;
  logic [2:0] preset_idx;
  logic manual_active, reseed;
  int errors = 0, checks = 0;
  logic [7:0] exp_rule [0:7] = '{8'd30, 8'd110, 8'd22, 8'd73, 8'd90, 8'd146, 8'd105, 8'd102};
  ca_rule_sequencer #(.DEBOUNCE_CYCLES(4), .AUTO_FRAMES(3), .NUM_PRESETS(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_next(btn_next), .btn_load(btn_load),
    .sw_auto(sw_auto), .manual_rule(manual_rule), .rule(rule), .rule_color(rule_color),
    .preset_idx(preset_idx), .manual_active(manual_active), .reseed(reseed));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask
  task automatic press(input bit load);
    if (load) btn_load = 1'b1; else btn_next = 1'b1;
    step(8);
    btn_load = 1'b0;
    btn_next = 1'b0;
    step(8);
  endtask
  initial begin
    step(2);
    chk("rst_rule", rule, 30);
    chk("rst_color", rule_color, 15);
    chk("rst_idx", preset_idx, 0);
    chk("rst_manual", manual_active, 0);
    chk("rst_reseed", reseed, 0);
    rst_n = 1'b1;
    step(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_rule", rule, 30);
      chk("idle_reseed", reseed, 0);
      step(2);
    end
    press(0);
    tick();
    chk("next_rule", rule, 110);
    chk("next_color", rule_color, 55);
    chk("next_idx", preset_idx, 1);
    chk("next_manual", manual_active, 0);
    chk("next_reseed", reseed, 1);
    step(1);
    chk("next_reseed_off", reseed, 0);
    chk("next_rule_hold", rule, 110);
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      step(1);
    end
    step(10);
    tick();
    chk("bounce_rule", rule, 110);
    chk("bounce_idx", preset_idx, 1);
    chk("bounce_reseed", reseed, 0);
    step(2);
    manual_rule = 8'hB4;
    press(1);
    press(0);
    tick();
    chk("load_rule", rule, 180);
    chk("load_color", rule_color, 26);
    chk("load_manual", manual_active, 1);
    chk("load_idx", preset_idx, 1);
    chk("load_reseed", reseed, 1);
    step(2);
    for (int k = 2; k < 8; k++) begin
      press(0);
      tick();
      chk("walk_idx", preset_idx, k);
      chk("walk_rule", rule, exp_rule[k]);
      step(1);
    end
    chk("walk_manual", manual_active, 0);
    sw_auto = 1'b1;
    step(3);
    tick();
    step(2);
    chk("auto_t1_rule", rule, 102);
    tick();
    step(2);
    chk("auto_t2_rule", rule, 102);
    tick();
    chk("auto_wrap_rule", rule, 30);
    chk("auto_wrap_idx", preset_idx, 0);
    chk("auto_wrap_reseed", reseed, 0);
    chk("auto_wrap_manual", manual_active, 0);
    step(2);
    for (int i = 0; i < 3; i++) begin
      tick();
      step(2);
    end
    chk("auto2_rule", rule, 110);
    chk("auto2_idx", preset_idx, 1);
    sw_auto = 1'b0;
    step(3);
    press(0);
    tick();
    step(1);
    press(0);
    tick();
    chk("pre_rst_rule", rule, 73);
    step(1);
    press(0);
    btn_load = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rule", rule, 30);
    chk("mid_rst_color", rule_color, 15);
    chk("mid_rst_idx", preset_idx, 0);
    chk("mid_rst_manual", manual_active, 0);
    chk("mid_rst_reseed", reseed, 0);
    btn_load = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    tick();
    chk("lost_rule", rule, 30);
    chk("lost_idx", preset_idx, 0);
    chk("lost_reseed", reseed, 0);
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
